// File: rtl/reg_host_pkg.sv
// reg_host_pkg: shared state encoding and defaults for the host access controller.
package reg_host_pkg;

  localparam int STATE_W         = 2;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_host_timer.sv
// reg_host_timer: access watchdog. Cleared when an access starts, counts every
// access cycle that passes without an acknowledge, flags the terminal count.
module reg_host_timer
  import reg_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;

  // Count waiting cycles; saturate at the terminal value so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != TERMINAL)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == TERMINAL);

endmodule

// File: rtl/reg_host_ctrl.sv
// reg_host_ctrl: host valid/ready front end for the register-access FSM.
// Optional access timeout is compiled in with the REG_HOST_TIMEOUT_EN macro.
module reg_host_ctrl
  import reg_host_pkg::*;
#(
  parameter int NUM_OF_REG     = 4,
  parameter int W_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wr,
  input  logic [W_WIDTH-1:0] req_addr,
  input  logic [W_WIDTH-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W_WIDTH-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               sel_en,
  output logic               wr_rd_s,
  output logic [W_WIDTH-1:0] addr,
  output logic [W_WIDTH-1:0] wdata,
  input  logic               ack,
  input  logic [W_WIDTH-1:0] rd_data
);

  // One extra bit so a register count equal to 2**W_WIDTH still compares correctly.
  localparam logic [W_WIDTH:0] ADDR_LIMIT = (W_WIDTH + 1)'(NUM_OF_REG);

  state_t             state_reg,     state_next;
  logic               req_ready_reg, req_ready_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [W_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic               rsp_err_reg,   rsp_err_next;
  logic               sel_en_reg,    sel_en_next;
  logic               wr_rd_s_reg,   wr_rd_s_next;
  logic [W_WIDTH-1:0] addr_reg,      addr_next;
  logic [W_WIDTH-1:0] wdata_reg,     wdata_next;

  logic in_range;
  logic timeout_hit;

  assign in_range = ({1'b0, req_addr} < ADDR_LIMIT);

`ifdef REG_HOST_TIMEOUT_EN
  logic tmr_clear;
  logic tmr_enable;

  assign tmr_clear  = (state_reg == IDLE) && req_valid && in_range;
  assign tmr_enable = (state_reg == ACCESS) && !ack;

  reg_host_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // State and all outputs are registered; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      sel_en_reg    <= 1'b0;
      wr_rd_s_reg   <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      sel_en_reg    <= sel_en_next;
      wr_rd_s_reg   <= wr_rd_s_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
    end
  end

  // Next-state and next-output decode; ack is only looked at during ACCESS.
  always_comb begin
    state_next     = state_reg;
    req_ready_next = req_ready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    sel_en_next    = sel_en_reg;
    wr_rd_s_next   = wr_rd_s_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;

    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          wr_rd_s_next   = req_wr;
          addr_next      = req_addr;
          wdata_next     = req_wdata;
          req_ready_next = 1'b0;
          if (in_range) begin
            state_next  = ACCESS;
            sel_en_next = 1'b1;
          end else begin
            // Bad address: answer straight away, never touch the register FSM.
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
          end
        end
      end

      ACCESS: begin
        if (ack) begin
          // ack beats a simultaneous timeout.
          state_next     = RESP;
          sel_en_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b0;
          rsp_rdata_next = wr_rd_s_reg ? '0 : rd_data;
        end else if (timeout_hit) begin
          state_next     = RESP;
          sel_en_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          req_ready_next = 1'b1;
        end
      end

      default: begin
        state_next     = IDLE;
        req_ready_next = 1'b1;
        rsp_valid_next = 1'b0;
        sel_en_next    = 1'b0;
      end
    endcase
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign sel_en    = sel_en_reg;
  assign wr_rd_s   = wr_rd_s_reg;
  assign addr      = addr_reg;
  assign wdata     = wdata_reg;

endmodule

// File: doc/reg_host_ctrl.md
# reg_host_ctrl

Host-side access controller that sits directly upstream of the switch register-access FSM. It accepts single read/write requests from a valid/ready host port and drives the `sel_en` / `wr_rd_s` / `addr` select handshake. It waits for the registered `ack`, captures read data, and returns one response per request on a valid/ready response port. It also screens out-of-range addresses and, when configured, bounds every access with a timeout.

## Interface
Parameters:
- NUM_OF_REG, 4, number of addressable registers downstream; legal addresses 0..NUM_OF_REG-1
- W_WIDTH, 8, address and data width
- TIMEOUT_CYCLES, 16, max cycles in ACCESS before an error response (used only with timeout compiled in)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  host request valid
- req_ready  out  1  high only in IDLE
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  W_WIDTH  register address
- req_wdata  in  W_WIDTH  write data
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  W_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  1 = address out of range or timeout
- sel_en  out  1  select to register FSM
- wr_rd_s  out  1  write/read select to register FSM
- addr  out  W_WIDTH  address to register FSM
- wdata  out  W_WIDTH  write data to register bank
- ack  in  1  registered acknowledge from register FSM
- rd_data  in  W_WIDTH  registered read data from register FSM, valid with ack

## Operation
- FSM states: IDLE, ACCESS, RESP; encoding is 2 bits.
- IDLE: `req_ready`=1. On `req_valid`:
  - register `req_wr`, `req_addr` and `req_wdata` into `wr_rd_s`, `addr` and `wdata`.
  - If `req_addr` < NUM_OF_REG: go to ACCESS and set `sel_en`=1 on the same edge.
  - Otherwise: go to RESP with `rsp_err`=1 and `rsp_rdata`=0. `sel_en` stays 0.
- ACCESS: `sel_en`=1. `wr_rd_s`, `addr` and `wdata` are stable. When `ack`=1:
  - capture `rd_data` into `rsp_rdata` for a read, or 0 for a write.
  - set `rsp_err`=0, clear `sel_en`, go to RESP.
- RESP: `rsp_valid`=1 and `sel_en`=0. On `rsp_ready`, go to IDLE. `rsp_rdata` and `rsp_err` hold until the handshake completes.
- `ack` is sampled only in ACCESS and ignored in IDLE and RESP.
- Reset mid-operation: FSM returns to IDLE and any in-flight response is dropped.
- Reset values: `req_ready`=1 (IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `sel_en`=0, `wr_rd_s`=0, `addr`=0, `wdata`=0, timeout counter 0.

## Timing
- Request accepted in cycle 0 (`req_valid` & `req_ready`).
- Cycles 1 and 2: `sel_en`=1.
- `ack` is first seen in cycle 2, because the register FSM adds one register stage.
- Cycle 3: `rsp_valid`=1 and `sel_en`=0.
- Minimum request-to-response latency is 3 cycles. Minimum request-to-request spacing is 4 cycles when `rsp_ready` is tied high.
- `sel_en` is always low for at least one cycle between accesses. This lets the downstream `ack` return to 0 before the next select.
- An out-of-range request gives `rsp_valid` in cycle 1 with no select activity.
- All outputs are registered; no combinational path runs from host inputs to register-side outputs.

## Configuration
- REG_HOST_TIMEOUT_EN defined:
  - The counter clears on entry to ACCESS and increments each ACCESS cycle without `ack`.
  - At count == TIMEOUT_CYCLES-1 with no `ack`, the FSM goes to RESP with `rsp_err`=1, `rsp_rdata`=0 and `sel_en` cleared.
  - If `ack` and the terminal count occur together, `ack` wins and no error is flagged.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter exists and ACCESS waits for `ack` indefinitely.

## Structure
- Shared package `reg_host_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP)
  - localparams for state width and default timeout.
- Sub-module `reg_host_timer` holds the timeout counter, with inputs clear/enable and output expired. It is instantiated only under REG_HOST_TIMEOUT_EN.

## Test plan
- Write addr 2, data 0xA5, `rsp_ready`=1 -> `sel_en` high in cycles 1–2, `wr_rd_s`=1, `wdata`=0xA5; `rsp_valid` in cycle 3 with `rsp_err`=0 and `rsp_rdata`=0.
- Read addr 3 with downstream returning 0x3C -> `rsp_rdata`=0x3C and `rsp_err`=0 in cycle 3.
- Read addr 7 (NUM_OF_REG=4) -> `sel_en` never asserts; `rsp_valid` in cycle 1 with `rsp_err`=1 and `rsp_rdata`=0.
- `rsp_ready` held low 5 cycles -> `rsp_valid`, `rsp_rdata` and `rsp_err` stable and `req_ready`=0 throughout; a new request is accepted the cycle after the handshake.
- With REG_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=16 and `ack` tied 0 -> `sel_en` high for 16 cycles, then `rsp_err`=1 and `sel_en`=0.
- Assert `rst_n` low during ACCESS -> `sel_en`=0 and `rsp_valid`=0 immediately; after release `req_ready`=1 and the next read completes normally.
